// File: rtl/regfile_writeback.sv
// Writeback initiator: buffers execute results in an in-order queue and drains
// one entry per cycle onto the register-file write port, tracking R0 in a shadow.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wbValid,
  output logic        wbReady,
  input  logic [3:0]  wbDest,
  input  logic [15:0] wbData,
  input  logic        wbR0En,
  input  logic [15:0] wbR0Data,
  input  logic        wbStall,
  output logic        registerWrite,
  output logic [3:0]  regWriteLocal,
  output logic [15:0] dataWrite,
  output logic [15:0] r0Write,
  output logic [15:0] pendingMask,
  output logic [15:0] r0Shadow
);

  logic [3:0]       dest_q   [DEPTH];
  logic [15:0]      data_q   [DEPTH];
  logic             r0en_q   [DEPTH];
  logic [15:0]      r0data_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [15:0]      r0_resolved;

  // Handshake: a result transfers on a rising edge where wbValid && wbReady;
  // wbReady depends only on occupancy, and execute holds its data until then.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wbReady = !full;
  assign push    = wbValid && !full;
  assign pop     = !empty && !wbStall;

  // The R0 port outranks a dest=0 data write; otherwise R0 keeps its value.
  always_comb begin
    r0_resolved = r0Shadow;
    if (r0en_q[rd_ptr]) begin
      r0_resolved = r0data_q[rd_ptr];
    end else if (dest_q[rd_ptr] == 4'd0) begin
      r0_resolved = data_q[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr]   <= wbDest;
      data_q[wr_ptr]   <= wbData;
      r0en_q[wr_ptr]   <= wbR0En;
      r0data_q[wr_ptr] <= wbR0Data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      registerWrite <= 1'b0;
      regWriteLocal <= 4'd0;
      dataWrite     <= 16'h0000;
      r0Write       <= 16'h0000;
      r0Shadow      <= 16'h0000;
    end else begin
      registerWrite <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        regWriteLocal <= dest_q[rd_ptr];
        dataWrite     <= data_q[rd_ptr];
        r0Write       <= r0_resolved;
        r0Shadow      <= r0_resolved;
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // An entry is occupied when its distance from the head is below count.
  always_comb begin
    pendingMask = 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count) begin
        pendingMask[dest_q[i]] = 1'b1;
        if (r0en_q[i]) begin
          pendingMask[0] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed pushes feed an expected queue that a
// strobe monitor drains and compares in order.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wbValid;
  logic        wbReady;
  logic [3:0]  wbDest;
  logic [15:0] wbData;
  logic        wbR0En;
  logic [15:0] wbR0Data;
  logic        wbStall;
  logic        registerWrite;
  logic [3:0]  regWriteLocal;
  logic [15:0] dataWrite;
  logic [15:0] r0Write;
  logic [15:0] pendingMask;
  logic [15:0] r0Shadow;

  int          total = 0;
  int          bad = 0;
  logic [35:0] exp_q[$];
  logic [15:0] model_shadow = 16'h0000;

  regfile_writeback #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .wbValid(wbValid), .wbReady(wbReady),
    .wbDest(wbDest), .wbData(wbData), .wbR0En(wbR0En), .wbR0Data(wbR0Data),
    .wbStall(wbStall),
    .registerWrite(registerWrite), .regWriteLocal(regWriteLocal),
    .dataWrite(dataWrite), .r0Write(r0Write),
    .pendingMask(pendingMask), .r0Shadow(r0Shadow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one result and holds it until accepted; expected strobe is queued
  // with the R0 value a correct writeback unit would resolve.
  task automatic push_entry(input logic [3:0] d, input logic [15:0] v,
                            input logic e, input logic [15:0] rv);
    int waited = 0;
    logic [15:0] r0;
    wbValid  = 1'b1;
    wbDest   = d;
    wbData   = v;
    wbR0En   = e;
    wbR0Data = rv;
    @(negedge clk);
    while (!wbReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("push_accept", wbReady, 1);
    if (wbReady) begin
      if (e) r0 = rv;
      else if (d == 4'd0) r0 = v;
      else r0 = model_shadow;
      model_shadow = r0;
      exp_q.push_back({d, v, r0});
      @(posedge clk);
      #1;
    end
    wbValid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && registerWrite) begin
      if (exp_q.size() == 0) begin
        check("strobe_unexpected", registerWrite, 0);
      end else begin
        logic [35:0] exp;
        exp = exp_q.pop_front();
        check("strobe_entry", {regWriteLocal, dataWrite, r0Write}, exp);
        check("r0_shadow", r0Shadow, exp[15:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached want test end");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [15:0] mask;
    reset_n  = 1'b0;
    wbValid  = 1'b0;
    wbDest   = 4'd0;
    wbData   = 16'h0000;
    wbR0En   = 1'b0;
    wbR0Data = 16'h0000;
    wbStall  = 1'b0;
    #12;
    check("rst_registerWrite", registerWrite, 0);
    check("rst_regWriteLocal", regWriteLocal, 0);
    check("rst_dataWrite", dataWrite, 0);
    check("rst_r0Write", r0Write, 0);
    check("rst_r0Shadow", r0Shadow, 0);
    check("rst_pendingMask", pendingMask, 0);
    check("rst_wbReady", wbReady, 1);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // Single write: one-cycle latency, pending bit lives for one cycle.
    push_entry(4'd5, 16'h1234, 1'b0, 16'h0000);
    @(negedge clk);
    check("single_no_strobe_yet", registerWrite, 0);
    check("single_mask_set", pendingMask, 16'h0020);
    @(negedge clk);
    check("single_strobe", registerWrite, 1);
    check("single_mask_clear", pendingMask, 16'h0000);
    idle(2);

    // R0 update then preservation; R0 as destination with and without the R0 port.
    push_entry(4'd3, 16'hAAAA, 1'b1, 16'h5555);
    push_entry(4'd7, 16'h0777, 1'b0, 16'h0000);
    push_entry(4'd0, 16'h00FF, 1'b0, 16'h0000);
    push_entry(4'd0, 16'h1111, 1'b1, 16'h2222);
    idle(4);

    // Fill while stalled; fifth result held until space frees.
    wbStall = 1'b1;
    push_entry(4'd1, 16'h1001, 1'b0, 16'h0000);
    push_entry(4'd2, 16'h2002, 1'b1, 16'h0BB0);
    push_entry(4'd4, 16'h4004, 1'b0, 16'h0000);
    push_entry(4'd6, 16'h6006, 1'b0, 16'h0000);
    check("full_ready_low", wbReady, 0);
    check("full_mask", pendingMask, 16'h0057);
    wbValid = 1'b1; wbDest = 4'd9; wbData = 16'h9009; wbR0En = 1'b0;
    idle(2);
    check("full_hold_ready_low", wbReady, 0);
    check("full_hold_mask", pendingMask, 16'h0057);
    wbStall = 1'b0;
    push_entry(4'd9, 16'h9009, 1'b0, 16'h0000);
    idle(8);
    check("full_drained_mask", pendingMask, 16'h0000);
    check("full_drained_queue", exp_q.size(), 0);

    // Steady push+pop at count=2.
    wbStall = 1'b1;
    push_entry(4'd2, 16'hC000, 1'b0, 16'h0000);
    push_entry(4'd3, 16'hC001, 1'b0, 16'h0000);
    wbStall = 1'b0;
    for (int k = 2; k < 12; k++) begin
      push_entry(4'(k + 2), 16'hC000 + 16'(k), 1'b0, 16'h0000);
      mask = (16'h0001 << (k + 1)) | (16'h0001 << (k + 2));
      check("steady_mask", pendingMask, mask);
      check("steady_ready", wbReady, 1);
    end
    idle(4);

    // Reset while draining three queued entries.
    wbStall = 1'b1;
    push_entry(4'd1, 16'h0101, 1'b1, 16'h7777);
    push_entry(4'd2, 16'h0202, 1'b0, 16'h0000);
    push_entry(4'd3, 16'h0303, 1'b0, 16'h0000);
    check("rstq_mask", pendingMask, 16'h000F);
    wbStall = 1'b0;
    idle(1);
    check("rstq_strobe_before", registerWrite, 1);
    reset_n = 1'b0;
    exp_q.delete();
    model_shadow = 16'h0000;
    #1;
    check("rstq_registerWrite", registerWrite, 0);
    check("rstq_regWriteLocal", regWriteLocal, 0);
    check("rstq_dataWrite", dataWrite, 0);
    check("rstq_r0Write", r0Write, 0);
    check("rstq_r0Shadow", r0Shadow, 0);
    check("rstq_mask_clear", pendingMask, 0);
    idle(2);
    reset_n = 1'b1;
    idle(6);
    check("rstq_after_mask", pendingMask, 0);
    check("rstq_after_shadow", r0Shadow, 0);
    check("rstq_after_strobe", registerWrite, 0);
    push_entry(4'd5, 16'h5555, 1'b0, 16'h0000);
    idle(4);

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
